// File: rtl/clkdiv_prog_if.sv
// Control/status bundle for clkdiv_prog: per-channel enable, period/high settings,
// the shared load strobe, and the divided clocks and tick pulses coming back.
interface clkdiv_prog_if #(
    parameter int CH    = 2,
    parameter int WIDTH = 16
);
    logic [CH-1:0]            en;
    logic [CH-1:0][WIDTH-1:0] div;
    logic [CH-1:0][WIDTH-1:0] high;
    logic                     load;
    logic [CH-1:0]            nclk;
    logic [CH-1:0]            tick;

    modport master (output en, div, high, load, input nclk, tick);
    modport slave  (input en, div, high, load, output nclk, tick);
endinterface

// File: rtl/clkdiv_prog.sv
// Multi-channel programmable clock divider with per-channel period/high counters.
// Optional CLKDIV_PROG_SYNC_EN: a load restarts every enabled channel in phase.
module clkdiv_prog_lane #(
    parameter int WIDTH   = 16,
    parameter int DEF_DIV = 500
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] div_i,
    input  logic [WIDTH-1:0] high_i,
    output logic             nclk_o,
    output logic             tick_o
);
    localparam logic [WIDTH-1:0] DEF_D = WIDTH'(DEF_DIV);
    localparam logic [WIDTH-1:0] DEF_H = WIDTH'(DEF_DIV / 2);

    logic [WIDTH-1:0] sh_div_q, sh_div_d, sh_high_q, sh_high_d;
    logic [WIDTH-1:0] act_div_q, act_div_d, act_high_q, act_high_d;
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             nclk_q, nclk_d, tick_q, tick_d;
    logic [WIDTH-1:0] eff_div, eff_high;

    always_comb begin
        // A load on the same cycle as a wrap must win over the stale shadow.
        eff_div    = load_i ? div_i  : sh_div_q;
        eff_high   = load_i ? high_i : sh_high_q;
        sh_div_d   = eff_div;
        sh_high_d  = eff_high;
        act_div_d  = act_div_q;
        act_high_d = act_high_q;
        cnt_d      = cnt_q;
        nclk_d     = 1'b0;
        tick_d     = 1'b0;
        if (!en_i || act_div_q < WIDTH'(2)) begin
            cnt_d      = '0;
            act_div_d  = eff_div;
            act_high_d = eff_high;
        end else begin
            nclk_d = (cnt_q < act_high_q);
            tick_d = (cnt_q == '0);
            if (cnt_q == act_div_q - WIDTH'(1)) begin
                cnt_d      = '0;
                act_div_d  = eff_div;
                act_high_d = eff_high;
            end else begin
                cnt_d = cnt_q + WIDTH'(1);
            end
        end
`ifdef CLKDIV_PROG_SYNC_EN
        if (en_i && load_i) begin
            cnt_d      = '0;
            act_div_d  = div_i;
            act_high_d = high_i;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sh_div_q   <= DEF_D;
            sh_high_q  <= DEF_H;
            act_div_q  <= DEF_D;
            act_high_q <= DEF_H;
            cnt_q      <= '0;
            nclk_q     <= 1'b0;
            tick_q     <= 1'b0;
        end else begin
            sh_div_q   <= sh_div_d;
            sh_high_q  <= sh_high_d;
            act_div_q  <= act_div_d;
            act_high_q <= act_high_d;
            cnt_q      <= cnt_d;
            nclk_q     <= nclk_d;
            tick_q     <= tick_d;
        end
    end

    assign nclk_o = nclk_q;
    assign tick_o = tick_q;
endmodule

module clkdiv_prog #(
    parameter int CH      = 2,
    parameter int WIDTH   = 16,
    parameter int DEF_DIV = 500
) (
    input  logic         clk,
    input  logic         rst,
    clkdiv_prog_if.slave bus
);
    for (genvar g = 0; g < CH; g++) begin : g_lane
        clkdiv_prog_lane #(.WIDTH(WIDTH), .DEF_DIV(DEF_DIV)) u_lane (
            .clk    (clk),
            .rst    (rst),
            .en_i   (bus.en[g]),
            .load_i (bus.load),
            .div_i  (bus.div[g]),
            .high_i (bus.high[g]),
            .nclk_o (bus.nclk[g]),
            .tick_o (bus.tick[g])
        );
    end
endmodule
